// File: rtl/data_ram_resp_pkg.sv
// Shared types and constants for the data-RAM responder.
// FSM encoding, enable polarities and the in-range helper.
package data_ram_resp_pkg;

    localparam logic        CHIP_ENABLE  = 1'b1;
    localparam logic        WRITE_ENABLE = 1'b1;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

    typedef enum logic [1:0] {
        RAM_ST_IDLE = 2'b00,
        RAM_ST_WAIT = 2'b01,
        RAM_ST_DONE = 2'b10
    } ram_st_e;

    function automatic int cnt_width(input int waits);
        return (waits > 0) ? $clog2(waits + 1) : 1;
    endfunction

    function automatic logic in_range(
        input logic [29:0] wa,
        input logic [31:0] base,
        input int          aw
    );
        logic [31:0] a;
        a = {wa, 2'b00};
        return (a >> (aw + 2)) == (base >> (aw + 2));
    endfunction

endpackage

// File: rtl/data_ram_resp_if.sv
// MEM-stage to data-RAM bus.
// The MEM stage is master; the RAM responder is slave.
interface data_ram_resp_if;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        stall_req;

    modport master (
        output ce, we, addr, sel, wdata,
        input  rdata, ready, err, stall_req
    );

    modport slave (
        input  ce, we, addr, sel, wdata,
        output rdata, ready, err, stall_req
    );
endinterface

// File: rtl/data_ram_resp_bank.sv
// Four byte-wide RAM lanes with per-lane write enable.
// Lane i holds wdata[8i+7:8i]; lane 3 is byte offset 0.
module data_ram_bank #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] q;

        // Byte write and registered read for this lane
        always_ff @(posedge clk) begin
            if (we[i]) mem[waddr] <= wdata[8*i+7 -: 8];
            q <= mem[raddr];
        end

        assign rdata[8*i+7 -: 8] = q;
    end
endmodule

// File: rtl/data_ram_resp.sv
// Data-RAM responder: wait-state FSM, request latch,
// range check and registered ready/err toward the pipeline.
module data_ram_resp
    import data_ram_resp_pkg::*;
#(
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic          clk,
    input  logic          rst,
    data_ram_resp_if.slave bus
);
    localparam int CNT_W = cnt_width(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    ram_st_e          state;
    logic [CNT_W-1:0] cnt;
    logic             req_we;
    logic [29:0]      req_wa;
    logic [3:0]       req_sel;
    logic [31:0]      req_wdata;
    logic             ready_q;
    logic             err_q;

    logic [29:0]      acc_wa;
    logic             acc_bad;
    logic             bank_wr;
    logic [31:0]      bank_q;
    logic             unused_lo;

    // In IDLE the access being accepted comes straight off the bus
    assign acc_wa    = (state == RAM_ST_IDLE) ? bus.addr[31:2] : req_wa;
    assign acc_bad   = ~in_range(acc_wa, BASE_ADDR, ADDR_W);
    assign unused_lo = ^bus.addr[1:0];

    assign bank_wr = ~rst & (state == RAM_ST_DONE)
                   & (bus.ce == CHIP_ENABLE)
                   & (req_we == WRITE_ENABLE) & ~err_q;

    data_ram_bank #(
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk   (clk),
        .we    ({4{bank_wr}} & req_sel),
        .waddr (req_wa[ADDR_W-1:0]),
        .wdata (req_wdata),
        .raddr (acc_wa[ADDR_W-1:0]),
        .rdata (bank_q)
    );

    // Request FSM with registered ready/err
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RAM_ST_IDLE;
            cnt       <= '0;
            req_we    <= 1'b0;
            req_wa    <= '0;
            req_sel   <= '0;
            req_wdata <= ZERO_WORD;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            unique case (state)
                RAM_ST_IDLE: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    if (bus.ce == CHIP_ENABLE) begin
                        req_we    <= bus.we;
                        req_wa    <= bus.addr[31:2];
                        req_sel   <= bus.sel;
                        req_wdata <= bus.wdata;
                        if (WAIT_CYCLES > 0) begin
                            state <= RAM_ST_WAIT;
                            cnt   <= CNT_INIT;
                        end else begin
                            state   <= RAM_ST_DONE;
                            ready_q <= 1'b1;
                            err_q   <= acc_bad;
                        end
                    end
                end
                RAM_ST_WAIT: begin
                    if (bus.ce != CHIP_ENABLE) begin
                        state <= RAM_ST_IDLE;
                    end else if (cnt == '0) begin
                        state   <= RAM_ST_DONE;
                        ready_q <= 1'b1;
                        err_q   <= acc_bad;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RAM_ST_DONE: begin
                    state   <= RAM_ST_IDLE;
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: begin
                    state   <= RAM_ST_IDLE;
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready     = ready_q;
    assign bus.err       = err_q;
    assign bus.rdata     = (ready_q & ~req_we & ~err_q) ? bank_q : ZERO_WORD;
    assign bus.stall_req = bus.ce & ~ready_q;

endmodule

// File: tb/tb_data_ram_resp.sv
// Directed bench for data_ram_resp.
// u1: WAIT_CYCLES=1, BASE 0; u0: WAIT_CYCLES=0, BASE 0x1000.
module tb_data_ram_resp;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    int          lat;
    int          stl;
    logic [31:0] rd;
    logic        e;
    bit          tmo;

    always #5 clk = ~clk;

    data_ram_resp_if b1 ();
    data_ram_resp_if b0 ();

    data_ram_resp #(
        .ADDR_W      (10),
        .WAIT_CYCLES (1),
        .BASE_ADDR   (32'h0)
    ) u1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    data_ram_resp #(
        .ADDR_W      (10),
        .WAIT_CYCLES (0),
        .BASE_ADDR   (32'h0000_1000)
    ) u0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    task automatic drive(input bit d, input bit c, input bit w,
                         input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] wd);
        if (d) begin
            b1.ce = c; b1.we = w; b1.addr = a; b1.sel = s; b1.wdata = wd;
        end else begin
            b0.ce = c; b0.we = w; b0.addr = a; b0.sel = s; b0.wdata = wd;
        end
    endtask

    // Runs one access; ce held through DONE, optionally kept high after
    task automatic access(input bit d, input bit w, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] wd,
                          input bit keep);
        @(negedge clk);
        drive(d, 1'b1, w, a, s, wd);
        #1;
        tmo = 1'b1; lat = 0; stl = 0; rd = '0; e = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (d ? b1.ready : b0.ready) begin
                lat = i;
                rd  = d ? b1.rdata : b0.rdata;
                e   = d ? b1.err : b0.err;
                tmo = 1'b0;
                break;
            end
            if (d ? b1.stall_req : b0.stall_req) stl++;
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        if (!keep) drive(d, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        checks++;
        if (tmo) begin
            errors++;
            $display("FAIL timeout addr=%h: no ready within 16 cycles", a);
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (b1.ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got=%b exp=0", b1.ready);
        end
        checks++;
        if (b1.err !== 1'b0) begin
            errors++; $display("FAIL reset_err got=%b exp=0", b1.err);
        end
        checks++;
        if (b1.rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata got=%h exp=0", b1.rdata);
        end
        checks++;
        if (b1.stall_req !== 1'b0) begin
            errors++; $display("FAIL reset_stall got=%b exp=0", b1.stall_req);
        end
    endtask

    task automatic test_word();
        access(1'b1, 1'b1, 32'h10, 4'b1111, 32'h1122_3344, 1'b0);
        checks++;
        if (lat !== 2 || stl !== 2) begin
            errors++; $display("FAIL sw_latency got=%0d/%0d exp=2/2", lat, stl);
        end
        checks++;
        if (rd !== 32'h0 || e !== 1'b0) begin
            errors++; $display("FAIL sw_resp got=%h/%b exp=0/0", rd, e);
        end
        access(1'b1, 1'b0, 32'h10, 4'b1111, 32'h0, 1'b0);
        checks++;
        if (lat !== 2 || stl !== 2) begin
            errors++; $display("FAIL lw_latency got=%0d/%0d exp=2/2", lat, stl);
        end
        checks++;
        if (rd !== 32'h1122_3344) begin
            errors++; $display("FAIL lw_data got=%h exp=11223344", rd);
        end
    endtask

    task automatic test_byte();
        access(1'b1, 1'b1, 32'h11, 4'b0100, 32'hAAAA_AAAA, 1'b0);
        access(1'b1, 1'b0, 32'h10, 4'b1111, 32'h0, 1'b0);
        checks++;
        if (rd !== 32'h11AA_3344) begin
            errors++; $display("FAIL sb_data got=%h exp=11aa3344", rd);
        end
    endtask

    task automatic test_half();
        access(1'b1, 1'b1, 32'h10, 4'b1111, 32'h1122_3344, 1'b0);
        access(1'b1, 1'b1, 32'h12, 4'b0011, 32'hBEEF_BEEF, 1'b0);
        checks++;
        if (stl !== 2) begin
            errors++; $display("FAIL sh_stall got=%0d exp=2", stl);
        end
        access(1'b1, 1'b0, 32'h10, 4'b1111, 32'h0, 1'b0);
        checks++;
        if (rd !== 32'h1122_BEEF) begin
            errors++; $display("FAIL sh_data got=%h exp=1122beef", rd);
        end
    endtask

    task automatic test_sel0();
        access(1'b1, 1'b1, 32'h10, 4'b0000, 32'h9999_9999, 1'b0);
        checks++;
        if (e !== 1'b0 || lat !== 2) begin
            errors++; $display("FAIL sel0_resp got=%b/%0d exp=0/2", e, lat);
        end
        access(1'b1, 1'b0, 32'h10, 4'b1111, 32'h0, 1'b0);
        checks++;
        if (rd !== 32'h1122_BEEF) begin
            errors++; $display("FAIL sel0_data got=%h exp=1122beef", rd);
        end
    endtask

    task automatic test_flush();
        int seen;
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 32'h10, 4'b1111, 32'hDEAD_BEEF);
        @(negedge clk);
        checks++;
        if (b1.stall_req !== 1'b1 || b1.ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_wait got=%b/%b exp=1/0",
                     b1.stall_req, b1.ready);
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (b1.ready) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL flush_ready got=%0d exp=0", seen);
        end
        access(1'b1, 1'b0, 32'h10, 4'b1111, 32'h0, 1'b0);
        checks++;
        if (rd !== 32'h1122_BEEF) begin
            errors++; $display("FAIL flush_data got=%h exp=1122beef", rd);
        end
    endtask

    task automatic test_range();
        access(1'b1, 1'b1, 32'h0, 4'b1111, 32'h0102_0304, 1'b0);
        access(1'b1, 1'b1, 32'h0001_0000, 4'b1111, 32'hCAFE_F00D, 1'b0);
        checks++;
        if (e !== 1'b1 || rd !== 32'h0 || lat !== 2) begin
            errors++;
            $display("FAIL range_wr got=%b/%h/%0d exp=1/0/2", e, rd, lat);
        end
        access(1'b1, 1'b0, 32'h0001_0000, 4'b1111, 32'h0, 1'b0);
        checks++;
        if (e !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL range_rd got=%b/%h exp=1/0", e, rd);
        end
        access(1'b1, 1'b0, 32'h0, 4'b1111, 32'h0, 1'b0);
        checks++;
        if (e !== 1'b0 || rd !== 32'h0102_0304) begin
            errors++;
            $display("FAIL range_keep got=%b/%h exp=0/01020304", e, rd);
        end
    endtask

    task automatic test_back_to_back();
        access(1'b1, 1'b1, 32'h20, 4'b1111, 32'hA1B2_C3D4, 1'b1);
        access(1'b1, 1'b0, 32'h20, 4'b1111, 32'h0, 1'b1);
        checks++;
        if (rd !== 32'hA1B2_C3D4 || lat !== 2) begin
            errors++; $display("FAIL b2b_raw got=%h/%0d exp=a1b2c3d4/2", rd, lat);
        end
        access(1'b1, 1'b1, 32'h23, 4'b0001, 32'h7777_7777, 1'b1);
        access(1'b1, 1'b0, 32'h20, 4'b1111, 32'h0, 1'b0);
        checks++;
        if (rd !== 32'hA1B2_C377) begin
            errors++; $display("FAIL b2b_byte got=%h exp=a1b2c377", rd);
        end
    endtask

    task automatic test_wait0();
        access(1'b0, 1'b1, 32'h1040, 4'b1111, 32'h5566_7788, 1'b0);
        checks++;
        if (lat !== 1 || stl !== 1 || e !== 1'b0) begin
            errors++;
            $display("FAIL w0_sw got=%0d/%0d/%b exp=1/1/0", lat, stl, e);
        end
        access(1'b0, 1'b0, 32'h1040, 4'b1111, 32'h0, 1'b0);
        checks++;
        if (rd !== 32'h5566_7788 || lat !== 1) begin
            errors++; $display("FAIL w0_lw got=%h/%0d exp=55667788/1", rd, lat);
        end
        access(1'b0, 1'b0, 32'h0040, 4'b1111, 32'h0, 1'b0);
        checks++;
        if (e !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL w0_range got=%b/%h exp=1/0", e, rd);
        end
    endtask

    task automatic test_rst_wait();
        access(1'b1, 1'b1, 32'h44, 4'b1111, 32'h0BAD_F00D, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 32'h44, 4'b1111, 32'h1234_5678);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (b1.ready !== 1'b0 || b1.err !== 1'b0 || b1.rdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_wait got=%b/%b/%h exp=0/0/0",
                     b1.ready, b1.err, b1.rdata);
        end
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        access(1'b1, 1'b0, 32'h44, 4'b1111, 32'h0, 1'b0);
        checks++;
        if (rd !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL rst_drop got=%h exp=0badf00d", rd);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_sel0();
        test_flush();
        test_range();
        test_back_to_back();
        test_wait0();
        test_rst_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
